i2s_rx: RTL
===========

# i2s_rx

Upstream I2S receiver for the stereo effect chain. It oversamples the codec's asynchronous I2S bus (bclk, lrclk, sdata) on the system clock and deserialises each left/right slot. Each completed stereo pair is presented as signed 32-bit words with a one-cycle valid strobe. Its `out_L`/`out_R` drive `in_L`/`in_R` of the first effect stage (mute) directly.

## Interface
- `DATA_BITS`, default 24: significant bits captured per slot, MSB first. Legal range 8..32.
- `clk` input 1: system clock. Must be ≥ 4× bclk, with bclk high and low each ≥ 2 clk periods.
- `reset_n` input 1: asynchronous, active-low reset.
- `i2s_bclk` input 1: codec bit clock. Asynchronous to `clk`.
- `i2s_lrclk` input 1: word select. 0 = left, 1 = right. Asynchronous.
- `i2s_sdata` input 1: serial data, MSB first. Asynchronous.
- `out_L` output signed 32: last complete left sample.
- `out_R` output signed 32: last complete right sample.
- `sample_valid` output 1: one-clk pulse when `out_L`/`out_R` update.
- `frame_err` output 1: one-clk pulse when a slot ends with fewer than `DATA_BITS` bits.

## Operation
- Input capture: all three pins pass through independent 2-FF synchronisers (reset 0). A third register on bclk gives `bclk_rise`. All actions below happen only in cycles where `bclk_rise` is high.
- Internal state: `lr_last` (lrclk seen at previous rise), `bit_cnt` (0..DATA_BITS, saturating), 32-bit shift register `sr`, `hold_L`, flags `synced` and `left_ok`.
- On every rise:
  - If `bit_cnt < DATA_BITS`: `sr <= {sr[30:0], sdata}` and `bit_cnt++`.
  - Otherwise sdata is ignored. Extra slot bits beyond `DATA_BITS` are dropped.
- Slot end: a rise where `lrclk_s != lr_last`.
  - The bit sampled at this rise still belongs to the ending slot (I2S one-bit delay).
  - The word is formed from `sr` including that bit.
  - Then `bit_cnt <= 0`, `sr <= 0`, `lr_last <= lrclk_s`.
  - The next rise carries the MSB of the new slot.
- Commit at slot end, only if `synced`:
  - If `bit_cnt` (after this rise's shift) < `DATA_BITS`: pulse `frame_err`, clear `left_ok`, discard the word.
  - If the ending slot was left: `hold_L <= word`, `left_ok <= 1`.
  - If the ending slot was right and `left_ok`: `out_L <= hold_L`, `out_R <= word`, pulse `sample_valid`, clear `left_ok`.
  - If the ending slot was right and `left_ok` is clear: discard the word.
- Synchronisation: after reset, `synced` = 0. The first slot end sets `synced` and commits nothing. Sync is never lost afterwards except by reset.
- Word alignment (default): left-aligned. `word = sr[DATA_BITS-1:0]` placed at bits 31..32-DATA_BITS; low bits are 0.
- Reset values: `out_L` = `out_R` = 0, `sample_valid` = `frame_err` = 0, all internal state 0.
- Reset mid-slot abandons the partial word. The first pair after release needs one slot end to sync, then a full left and a full right slot.

## Timing
- A pin edge first captured by `clk` edge k reaches sync stage 2 at edge k+1. `bclk_rise` is high in cycle k+1..k+2, and outputs and state update at edge k+2.
- `sample_valid` and `frame_err` are high for exactly one clk. They never assert in the same cycle.
- `out_L`/`out_R` are stable between `sample_valid` pulses. Downstream may sample them at any time.
- A new pair arrives once per lrclk period. Downstream has no backpressure.

## Configuration
- `I2S_RX_SIGN_EXT_EN`:
  - Defined: the word is right-aligned, `word[DATA_BITS-1:0] = sr`, and bits 31..DATA_BITS are copies of bit DATA_BITS-1 (integer scaling).
  - Undefined: left-aligned, zero-padded as in Operation (full-scale scaling).
  - With DATA_BITS = 32 both modes are identical.

## Test plan
- Basic pair:
  - Setup: DATA_BITS=24, 32 bclk/slot, clk = 16× bclk, sync frame first, left 0x123456, right 0xFEDCBA, zeros after bit 24.
  - Required: `out_L` = 0x12345600, `out_R` = 0xFEDCBA00, one `sample_valid` pulse at the right slot end.
- Sign extension:
  - Same stimulus as the basic pair, with `I2S_RX_SIGN_EXT_EN` defined.
  - Required: `out_L` = 0x00123456, `out_R` = 0xFFFEDCBA.
- Extra bits: bits 25..32 of each slot driven to 1. Required: outputs identical to the basic pair.
- Short slot:
  - Stimulus: left slot of 16 bclks.
  - Required: `frame_err` pulses once at the left slot end. The following right slot produces no `sample_valid`, and outputs hold their prior values. The next full pair produces valid output normally.
- Reset mid-slot:
  - Stimulus: `reset_n` low for 3 clk during a left slot.
  - Required: outputs read 0 immediately (asynchronously). No `sample_valid` until one sync slot end plus a full left and right pair. That pair is then output correctly.
- Idle bus: lrclk toggling with bclk held low. Required: no `sample_valid`, no `frame_err`, outputs unchanged.

Source files
------------

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx
//  Description : I2S receiver. Oversamples the asynchronous codec bus
//                (bclk, lrclk, sdata) on clk and deserialises each left/right
//                slot. Every complete stereo pair is presented as signed
//                32-bit words with a one-cycle valid strobe.
//  Ports       : clk           system clock (>= 4x bclk)
//                reset_n       asynchronous active-low reset
//                i2s_bclk      codec bit clock (async)
//                i2s_lrclk     word select, 0 = left, 1 = right (async)
//                i2s_sdata     serial data, MSB first (async)
//                out_L/out_R   last complete left/right sample
//                sample_valid  one-clk pulse when out_L/out_R update
//                frame_err     one-clk pulse when a slot ends short
//  Config      : I2S_RX_SIGN_EXT_EN defined   -> right-aligned, sign-extended
//                I2S_RX_SIGN_EXT_EN undefined -> left-aligned, zero-padded
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx #(
    parameter int DATA_BITS = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i2s_bclk,
    input  logic               i2s_lrclk,
    input  logic               i2s_sdata,
    output logic signed [31:0] out_L,
    output logic signed [31:0] out_R,
    output logic               sample_valid,
    output logic               frame_err
);

    localparam int               c_CNT_W = $clog2(DATA_BITS + 1);
    localparam int               c_PAD   = 32 - DATA_BITS;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DATA_BITS);

    // Synchroniser chains; the third bclk stage exists only for edge detect.
    logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
    logic r_lrclk_s1, r_lrclk_s2;
    logic r_sdata_s1, r_sdata_s2;

    logic               r_lr_last;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [31:0]        r_sr;
    logic signed [31:0] r_hold_L;
    logic               r_synced;
    logic               r_left_ok;

    logic               w_bclk_rise;
    logic               w_slot_end;
    logic               w_room;
    logic [31:0]        w_sr_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_short;
    logic signed [31:0] w_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_s1  <= 1'b0;
            r_bclk_s2  <= 1'b0;
            r_bclk_s3  <= 1'b0;
            r_lrclk_s1 <= 1'b0;
            r_lrclk_s2 <= 1'b0;
            r_sdata_s1 <= 1'b0;
            r_sdata_s2 <= 1'b0;
        end else begin
            r_bclk_s1  <= i2s_bclk;
            r_bclk_s2  <= r_bclk_s1;
            r_bclk_s3  <= r_bclk_s2;
            r_lrclk_s1 <= i2s_lrclk;
            r_lrclk_s2 <= r_lrclk_s1;
            r_sdata_s1 <= i2s_sdata;
            r_sdata_s2 <= r_sdata_s1;
        end
    end

    always_comb begin
        w_bclk_rise = r_bclk_s2 & ~r_bclk_s3;
        w_slot_end  = (r_lrclk_s2 != r_lr_last);
        w_room      = (r_bit_cnt < c_FULL);
        // Bits past DATA_BITS are dropped; the counter saturates.
        w_sr_next   = w_room ? {r_sr[30:0], r_sdata_s2} : r_sr;
        w_cnt_next  = w_room ? (r_bit_cnt + c_CNT_W'(1)) : r_bit_cnt;
        // The bit sampled at the slot-end rise still belongs to the old slot,
        // so the length check uses the post-shift count.
        w_short     = (w_cnt_next < c_FULL);
`ifdef I2S_RX_SIGN_EXT_EN
        // Push the word to the top, then arithmetic-shift back down to
        // replicate bit DATA_BITS-1 into the upper bits.
        w_word      = $signed(w_sr_next << c_PAD) >>> c_PAD;
`else
        // sr only ever holds DATA_BITS valid bits above zeros, so a plain
        // shift left-aligns the word with zero fill below.
        w_word      = $signed(w_sr_next << c_PAD);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lr_last    <= 1'b0;
            r_bit_cnt    <= '0;
            r_sr         <= '0;
            r_hold_L     <= '0;
            r_synced     <= 1'b0;
            r_left_ok    <= 1'b0;
            out_L        <= '0;
            out_R        <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (w_bclk_rise) begin
                if (w_slot_end) begin
                    r_sr      <= '0;
                    r_bit_cnt <= '0;
                    r_lr_last <= r_lrclk_s2;
                    if (!r_synced) begin
                        // First slot boundary only establishes alignment.
                        r_synced <= 1'b1;
                    end else if (w_short) begin
                        frame_err <= 1'b1;
                        r_left_ok <= 1'b0;
                    end else if (!r_lr_last) begin
                        r_hold_L  <= w_word;
                        r_left_ok <= 1'b1;
                    end else if (r_left_ok) begin
                        out_L        <= r_hold_L;
                        out_R        <= w_word;
                        sample_valid <= 1'b1;
                        r_left_ok    <= 1'b0;
                    end
                end else begin
                    r_sr      <= w_sr_next;
                    r_bit_cnt <= w_cnt_next;
                end
            end
        end
    end

endmodule
`default_nettype wire
